// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-unit results queue in a FIFO.
// Optional `WB_STAT_EN adds a 32-bit counter of forced FIFO drains on stat_force_cnt.
module wb_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          pipe_valid,
  input  logic [IDX_W-1:0]              pipe_rd,
  input  logic [DATA_W-1:0]             pipe_data,
  output logic                          pipe_stall,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [IDX_W-1:0]              lu_rd,
  input  logic [DATA_W-1:0]             lu_data,
  output logic                          rf_we,
  output logic [IDX_W-1:0]              rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   stat_force_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX) + 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                rf_we_q, rf_we_d;
  logic [IDX_W-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

  logic [IDX_W-1:0]    mem_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_data_q [FIFO_DEPTH];

  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                grant;
  logic [IDX_W-1:0]    grant_rd;
  logic [DATA_W-1:0]   grant_data;

  // Acceptance uses only the registered count, so a full FIFO refuses a push even while popping.
  assign fifo_empty = (count_q == '0);
  assign lu_ready   = (count_q < CW'(FIFO_DEPTH));
  assign push       = lu_valid & lu_ready;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    pop        = 1'b0;
    grant      = 1'b0;
    grant_rd   = pipe_rd;
    grant_data = pipe_data;
    pipe_stall = 1'b0;
    unique case (state_q)
      NORMAL: begin
        if (pipe_valid) begin
          grant = 1'b1;
          if (!fifo_empty) begin
            if (starve_q == STARVE_LAST) begin
              state_d  = FORCE;
              starve_d = '0;
            end else begin
              starve_d = starve_q + 1'b1;
            end
          end else begin
            starve_d = '0;
          end
        end else begin
          starve_d = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            grant      = 1'b1;
            grant_rd   = mem_rd_q[rd_ptr_q];
            grant_data = mem_data_q[rd_ptr_q];
          end
        end
      end
      FORCE: begin
        pipe_stall = pipe_valid;
        starve_d   = '0;
        state_d    = NORMAL;
        if (!fifo_empty) begin
          pop        = 1'b1;
          grant      = 1'b1;
          grant_rd   = mem_rd_q[rd_ptr_q];
          grant_data = mem_data_q[rd_ptr_q];
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // r0 writes are consumed like any other grant but never raise the write enable.
  always_comb begin
    rf_we_d    = grant && (grant_rd != '0);
    rf_waddr_d = grant ? grant_rd   : rf_waddr_q;
    rf_wdata_d = grant ? grant_data : rf_wdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= lu_rd;
      mem_data_q[wr_ptr_q] <= lu_data;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;

`ifdef WB_STAT_EN
  logic [31:0] stat_q, stat_d;

  always_comb begin
    stat_d = (state_q == FORCE) ? stat_q + 32'd1 : stat_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_force_cnt = stat_q;
`else
  assign stat_force_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: idle drain, starvation force, full FIFO, wrap, r0, async reset.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rstn;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  fifo_count;
  logic [31:0] stat_force_cnt;

  int unsigned n_checks;
  int unsigned n_errors;

`ifdef WB_STAT_EN
  localparam logic [31:0] EXP_STAT_AFTER_FORCE = 32'd1;
`else
  localparam logic [31:0] EXP_STAT_AFTER_FORCE = 32'd0;
`endif

  wb_port_arbiter #(
    .DATA_W    (32),
    .IDX_W     (5),
    .FIFO_DEPTH(4),
    .STARVE_MAX(8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .pipe_valid    (pipe_valid),
    .pipe_rd       (pipe_rd),
    .pipe_data     (pipe_data),
    .pipe_stall    (pipe_stall),
    .lu_valid      (lu_valid),
    .lu_ready      (lu_ready),
    .lu_rd         (lu_rd),
    .lu_data       (lu_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .fifo_count    (fifo_count),
    .stat_force_cnt(stat_force_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v;
    pipe_rd    = rd;
    pipe_data  = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v;
    lu_rd    = rd;
    lu_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    set_pipe(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    repeat (2) step();
    rstn = 1'b1;
    step();

    // reset state
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_we", rf_we, 0);
    check_eq("rst_waddr", rf_waddr, 0);
    check_eq("rst_wdata", rf_wdata, 0);
    check_eq("rst_lu_ready", lu_ready, 1);
    check_eq("rst_stall", pipe_stall, 0);
    check_eq("rst_stat", stat_force_cnt, 0);

    // idle pipe: long-unit result lands two cycles after push
    set_lu(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1 check_eq("idle_lu_ready", lu_ready, 1);
    step();
    set_lu(1'b0, 5'd0, 32'd0);
    #1 check_eq("idle_c1_count", fifo_count, 1);
    check_eq("idle_c1_we", rf_we, 0);
    step();
    check_eq("idle_c2_we", rf_we, 1);
    check_eq("idle_c2_waddr", rf_waddr, 5);
    check_eq("idle_c2_wdata", rf_wdata, 64'hDEAD_BEEF);
    check_eq("idle_c2_count", fifo_count, 0);
    step();
    check_eq("idle_c3_we", rf_we, 0);

    // starvation: 8 contended pipe grants, then one forced drain
    set_pipe(1'b1, 5'd10, 32'h100);
    set_lu(1'b1, 5'd7, 32'h1111_2222);
    step();
    set_lu(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      set_pipe(1'b1, 5'(10 + k), 32'h100 + 32'(k));
      #1 check_eq("starve_stall", pipe_stall, 0);
      check_eq("starve_we", rf_we, 1);
      check_eq("starve_waddr", rf_waddr, 64'(10 + k - 1));
      step();
    end
    set_pipe(1'b1, 5'd19, 32'h200);
    #1 check_eq("force_stall", pipe_stall, 1);
    check_eq("force_prev_waddr", rf_waddr, 18);
    step();
    check_eq("force_resume_stall", pipe_stall, 0);
    check_eq("force_we", rf_we, 1);
    check_eq("force_waddr", rf_waddr, 7);
    check_eq("force_wdata", rf_wdata, 64'h1111_2222);
    check_eq("force_count", fifo_count, 0);
    check_eq("force_stat", stat_force_cnt, EXP_STAT_AFTER_FORCE);
    step();
    check_eq("resume_waddr", rf_waddr, 19);
    check_eq("resume_wdata", rf_wdata, 64'h200);
    set_pipe(1'b0, 5'd0, 32'd0);
    step();

    // full FIFO while pipe busy
    set_pipe(1'b1, 5'd1, 32'h77);
    for (int i = 0; i < 4; i++) begin
      set_lu(1'b1, 5'(21 + i), 32'hA1 + 32'(i));
      step();
    end
    check_eq("full_count", fifo_count, 4);
    check_eq("full_lu_ready", lu_ready, 0);
    set_lu(1'b1, 5'd30, 32'hEE);
    step();
    check_eq("full_extra_count", fifo_count, 4);
    check_eq("full_extra_ready", lu_ready, 0);
    set_lu(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    step();
    check_eq("pop1_count", fifo_count, 3);
    check_eq("pop1_lu_ready", lu_ready, 1);
    check_eq("pop1_we", rf_we, 1);
    check_eq("pop1_waddr", rf_waddr, 21);
    check_eq("pop1_wdata", rf_wdata, 64'hA1);

    // simultaneous push+pop at count 2 across pointer wrap
    step();
    check_eq("pp_c7_count", fifo_count, 2);
    check_eq("pp_c7_waddr", rf_waddr, 22);
    set_lu(1'b1, 5'd25, 32'hA5);
    step();
    check_eq("pp_c8_count", fifo_count, 2);
    check_eq("pp_c8_waddr", rf_waddr, 23);
    set_lu(1'b1, 5'd26, 32'hA6);
    step();
    check_eq("pp_c9_count", fifo_count, 2);
    check_eq("pp_c9_waddr", rf_waddr, 24);
    check_eq("pp_c9_wdata", rf_wdata, 64'hA4);
    set_lu(1'b0, 5'd0, 32'd0);
    step();
    check_eq("pp_c10_count", fifo_count, 1);
    check_eq("pp_c10_waddr", rf_waddr, 25);
    check_eq("pp_c10_wdata", rf_wdata, 64'hA5);
    step();
    check_eq("pp_c11_count", fifo_count, 0);
    check_eq("pp_c11_waddr", rf_waddr, 26);
    check_eq("pp_c11_wdata", rf_wdata, 64'hA6);
    step();
    check_eq("pp_c12_we", rf_we, 0);

    // r0 destination is granted but never written
    set_pipe(1'b1, 5'd0, 32'h55);
    #1 check_eq("r0_stall", pipe_stall, 0);
    step();
    check_eq("r0_we", rf_we, 0);
    set_pipe(1'b0, 5'd0, 32'd0);
    step();

    // asynchronous reset with three entries queued
    set_pipe(1'b1, 5'd3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      set_lu(1'b1, 5'(40 + i), 32'hC0 + 32'(i));
      step();
    end
    set_lu(1'b0, 5'd0, 32'd0);
    #1 check_eq("mid_count", fifo_count, 3);
    check_eq("mid_we", rf_we, 1);
    #1 rstn = 1'b0;
    #1 check_eq("arst_count", fifo_count, 0);
    check_eq("arst_we", rf_we, 0);
    check_eq("arst_lu_ready", lu_ready, 1);
    check_eq("arst_waddr", rf_waddr, 0);
    check_eq("arst_stat", stat_force_cnt, 0);
    check_eq("arst_stall", pipe_stall, 0);
    set_pipe(1'b0, 5'd0, 32'd0);
    step();
    rstn = 1'b1;
    step();
    check_eq("post_rst_count", fifo_count, 0);
    check_eq("post_rst_we", rf_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
